// File: rtl/ppu_pkg.sv
// rtl/ppu_pkg.sv - shared constants and state encoding for the program loader
package ppu_pkg;

    localparam int WORD_BYTES = 4;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_LOAD    = 3'd1;
    localparam logic [2:0] ST_WRITE   = 3'd2;
    localparam logic [2:0] ST_RELEASE = 3'd3;
    localparam logic [2:0] ST_DONE    = 3'd4;
    localparam logic [2:0] ST_ERR     = 3'd5;

    typedef enum logic [2:0] {
        IDLE    = ST_IDLE,
        LOAD    = ST_LOAD,
        WRITE   = ST_WRITE,
        RELEASE = ST_RELEASE,
        DONE    = ST_DONE,
        ERR     = ST_ERR
    } state_t;

endpackage

// File: rtl/byte_packer.sv
// rtl/byte_packer.sv - shifts accepted bytes into a big-endian 32-bit word
module byte_packer
    import ppu_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic [31:0] word,
    output logic        word_done
);

    logic [1:0]  idx_q;
    logic [31:0] word_q;

    // The byte arriving now completes the word when three are already held.
    assign word_done = in_valid && (idx_q == 2'(WORD_BYTES - 1));
    assign word      = word_q;

    // Shift left so the first byte of a group ends up in bits 31:24; clear drops a partial word.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idx_q  <= 2'd0;
            word_q <= 32'd0;
        end else if (clear) begin
            idx_q  <= 2'd0;
        end else if (in_valid) begin
            word_q <= {word_q[23:0], in_data};
            idx_q  <= idx_q + 2'd1;
        end
    end

endmodule

// File: rtl/program_loader.sv
// rtl/program_loader.sv - streams a byte image into memory as words, then releases the CPU
module program_loader
    import ppu_pkg::*;
#(
    parameter int ADDR_W      = 9,
    parameter int RELEASE_CYC = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   byte_count,
    input  logic              s_valid,
    input  logic [7:0]        s_data,
    output logic              s_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              cpu_reset,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [7:0]        checksum
);

    localparam int                REL_W     = (RELEASE_CYC > 1) ? $clog2(RELEASE_CYC) : 1;
    localparam logic [REL_W-1:0]  REL_LAST  = REL_W'(RELEASE_CYC - 1);
    localparam logic [ADDR_W+1:0] MEM_BYTES = {2'b01, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0]   WORD_CNT  = (ADDR_W+1)'(WORD_BYTES);
    localparam logic [ADDR_W-1:0] WORD_STEP = ADDR_W'(WORD_BYTES);

    state_t            state;
    state_t            state_nx;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W:0]   rem_q;
    logic [7:0]        csum_q;
    logic              cpu_reset_q;
    logic [REL_W-1:0]  rel_cnt;

    logic [ADDR_W+1:0] end_addr;
    logic              req_bad;
    logic              start_ok;
    logic              load_go;
    logic              abort_hit;
    logic              accept;
    logic              word_done;
    logic              last_word;
    logic              rel_last;

    // Two extra bits so base+count cannot wrap while checking against the memory size.
    assign end_addr  = (ADDR_W+2)'(base_addr) + (ADDR_W+2)'(byte_count);
    assign req_bad   = (byte_count == '0) || (byte_count[1:0] != 2'b00) ||
                       (base_addr[1:0] != 2'b00) || (end_addr > MEM_BYTES);
    assign start_ok  = start && ((state == IDLE) || (state == DONE) || (state == ERR));
    assign load_go   = start_ok && !req_bad;
    assign abort_hit = abort && ((state == LOAD) || (state == WRITE));
    // Abort wins over a byte offered in the same cycle.
    assign accept    = (state == LOAD) && s_valid && !abort;
    assign last_word = (rem_q == WORD_CNT);
    assign rel_last  = (rel_cnt == REL_LAST);

    assign mem_addr  = addr_q;
    assign checksum  = csum_q;
    assign cpu_reset = cpu_reset_q;

    byte_packer u_packer (
        .clk       (clk),
        .reset     (reset),
        .clear     (load_go || abort_hit),
        .in_valid  (accept),
        .in_data   (s_data),
        .word      (mem_wdata),
        .word_done (word_done)
    );

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state and state-decoded outputs.
    always_comb begin
        state_nx = state;
        s_ready  = 1'b0;
        mem_we   = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        err      = 1'b0;
        case (state)
            IDLE, DONE, ERR: begin
                done = (state == DONE);
                err  = (state == ERR);
                if (start) begin
                    state_nx = req_bad ? ERR : LOAD;
                end
            end
            LOAD: begin
                s_ready = 1'b1;
                busy    = 1'b1;
                if (abort) begin
                    state_nx = IDLE;
                end else if (word_done) begin
                    state_nx = WRITE;
                end
            end
            WRITE: begin
                busy   = 1'b1;
                mem_we = !abort;
                if (abort) begin
                    state_nx = IDLE;
                end else begin
                    state_nx = last_word ? RELEASE : LOAD;
                end
            end
            RELEASE: begin
                busy = 1'b1;
                if (rel_last) begin
                    state_nx = DONE;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // Address/count bookkeeping, checksum, release timer and the CPU reset flop.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr_q      <= '0;
            rem_q       <= '0;
            csum_q      <= 8'd0;
            cpu_reset_q <= 1'b1;
            rel_cnt     <= '0;
        end else begin
            if (load_go) begin
                addr_q      <= base_addr;
                rem_q       <= byte_count;
                csum_q      <= 8'd0;
                cpu_reset_q <= 1'b1;
            end
            if (accept) begin
                csum_q <= csum_q ^ s_data;
            end
            if ((state == WRITE) && !abort) begin
                addr_q <= addr_q + WORD_STEP;
                rem_q  <= rem_q - WORD_CNT;
            end
            if (abort_hit) begin
                cpu_reset_q <= 1'b1;
            end
            if (state == RELEASE) begin
                if (rel_last) begin
                    rel_cnt     <= '0;
                    cpu_reset_q <= 1'b0;
                end else begin
                    rel_cnt <= rel_cnt + 1'b1;
                end
            end else begin
                rel_cnt <= '0;
            end
        end
    end

endmodule
